uart_sequencer: RTL
===================

Name: uart_sequencer

Overview:
- Hardware host controller for the UART block. It takes the place of the soft processor on the UART's OUT_PORT/IN_PORT/READ/WRITE/INT_ACK interface.
- Programs the UART configuration register after reset and on request.
- Services UART interrupts by acknowledging them, polling status and draining received bytes.
- Feeds transmit bytes from an internal FIFO whenever the transmitter reports ready.

Parameters:
- CFG_INIT, 8'h00: configuration written after reset. Bits [7:4] baud select, [3] EIGHT, [2] PEN, [1] OHEL, [0] unused.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of 2, minimum 2.
- HOLD_CYC, 2: cycles to wait after a WRITE0 before status is sampled again.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tx_push  in  1  push tx_din into the TX FIFO; ignored when tx_full=1
- tx_din  in  8  byte to transmit
- tx_full  out  1  TX FIFO full
- tx_empty  out  1  TX FIFO empty
- cfg_wr  in  1  request a reconfiguration with cfg_din; held pending until serviced
- cfg_din  in  8  new configuration value
- rx_valid  out  1  one-cycle strobe; the rx_* fields are valid this cycle
- rx_data  out  8  received byte
- rx_perr, rx_ferr, rx_ovf  out  1 each  error flags captured with the byte
- busy  out  1  high whenever the state machine is not in IDLE
- OUT_PORT  out  8  UART write data
- WRITE2  out  1  UART config write strobe
- WRITE0  out  1  UART transmit load strobe
- READ  out  3  UART read select, one-hot: 001 data, 010 status
- INT_ACK  out  1  UART interrupt acknowledge
- IN_PORT  in  8  UART read data; combinational from READ, sampled in the same cycle READ is driven
- INTERRUPT  in  1  UART interrupt request

Behaviour:
- Reset values: all outputs 0, FIFO empty (tx_empty=1), state CFG, pending cfg cleared, config value = CFG_INIT.
- All UART strobe outputs and READ are registered one-cycle pulses. At most one of WRITE2, WRITE0, READ, INT_ACK is active in any cycle.
- CFG: OUT_PORT=config value, WRITE2=1 for 1 cycle -> IDLE.
- IDLE, evaluated in priority order:
  - pending cfg -> CFG, with config value = latched cfg_din.
  - INTERRUPT=1 -> ACK.
  - !tx_empty -> STAT.
  - otherwise stay in IDLE.
- ACK: INT_ACK=1 for 1 cycle -> STAT.
- STAT: READ=010. Capture IN_PORT into stat: bit0 RX_RDY, bit1 TX_RDY, bit2 PERR, bit3 FERR, bit4 OVF. Next state:
  - RX_RDY=1 -> RDRX.
  - else TX_RDY=1 and !tx_empty -> WRTX.
  - else IDLE.
- RDRX: READ=001; rx_data=IN_PORT; error flags taken from stat; rx_valid=1 on the following cycle (registered). Next state: WRTX if stat TX_RDY=1 and !tx_empty, else IDLE.
- WRTX: OUT_PORT=FIFO head, WRITE0=1, pop FIFO -> HOLD.
- HOLD: count HOLD_CYC cycles -> IDLE. This prevents a double load before TX_RDY falls.
- cfg_wr latches cfg_din and sets pending in any state. A later cfg_wr before service overwrites the latched value. Pending clears on entry to CFG.
- FIFO boundaries:
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Push while full is dropped; contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Use an occupancy counter of width log2(FIFO_DEPTH)+1.
- INTERRUPT asserted mid-sequence is not lost. The UART latches it; it is serviced on the next IDLE visit.
- The UART's reset value of INTERRUPT=1 produces one ACK/STAT pass right after the initial CFG.
- Asynchronous reset mid-operation aborts immediately; the sequencer restarts at CFG with CFG_INIT.

Optional Feature:
- UART_SEQ_ERR_DROP_EN:
  - When defined: a byte whose stat PERR or FERR is set is read (this clears the UART) but rx_valid is not asserted. An 8-bit saturating output err_drop_cnt (reset 0) increments per dropped byte.
  - When undefined: every byte is delivered with its flags, and err_drop_cnt does not exist.

Test Plan:
- Reset with CFG_INIT=8'h38 -> WRITE2 pulse with OUT_PORT=8'h38 in the first cycle after reset release. Then INT_ACK, then READ=010, back to IDLE with no WRITE0.
- Push 8'hA5, 8'h5A; UART model with TX_RDY=1, dropping TX_RDY for 10 cycles after each load -> exactly two WRITE0 pulses, OUT_PORT 8'hA5 then 8'h5A, tx_empty=1 after.
- Model raises INTERRUPT with status 8'h01 and data 8'hC3 -> INT_ACK, READ=010, READ=001 in order; rx_valid for 1 cycle with rx_data=8'hC3 and all flags 0.
- Status 8'h05 (PERR) with data 8'h11 -> macro undefined: rx_valid with rx_perr=1. Macro defined: no rx_valid and err_drop_cnt=1.
- Push FIFO_DEPTH+2 bytes with TX_RDY=0 -> tx_full=1, last 2 pushes dropped. Raise TX_RDY -> exactly FIFO_DEPTH loads, in order.
- cfg_wr=1 with cfg_din=8'h9C during WRTX -> WRITE2 with OUT_PORT=8'h9C on the first IDLE exit after HOLD; assert reset mid-HOLD -> all strobes 0 and restart at CFG with CFG_INIT.

Source files
------------

// File: rtl/uart_sequencer.sv
// Hardware host controller for the UART: configures it, services its interrupts, drains RX and feeds TX.
// Optional build macro UART_SEQ_ERR_DROP_EN drops bytes flagged with PERR/FERR and counts them.
module uart_sequencer #(
  parameter logic [7:0] CFG_INIT   = 8'h00,
  parameter int         FIFO_DEPTH = 8,
  parameter int         HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_push,
  input  logic [7:0] tx_din,
  output logic       tx_full,
  output logic       tx_empty,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_din,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_ovf,
`ifdef UART_SEQ_ERR_DROP_EN
  output logic [7:0] err_drop_cnt,
`endif
  output logic       busy,
  output logic [7:0] OUT_PORT,
  output logic       WRITE2,
  output logic       WRITE0,
  output logic [2:0] READ,
  output logic       INT_ACK,
  input  logic [7:0] IN_PORT,
  input  logic       INTERRUPT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    S_CFG, S_IDLE, S_ACK, S_STAT, S_RDRX, S_WRTX, S_HOLD
  } state_t;

  state_t          state;
  logic [4:0]      stat;
  logic [7:0]      cfg_val;
  logic [7:0]      cfg_lat;
  logic            cfg_pend;
  logic [HW-1:0]   hold_cnt;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop;
  logic [7:0]      fifo_head;
  logic            unused_in;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tx_full   = (count == CW'(FIFO_DEPTH));
  assign tx_empty  = (count == '0);
  assign push_ok   = tx_push & ~tx_full;
  assign fifo_head = mem[rd_ptr];
  assign unused_in = ^IN_PORT[7:5];

  // A load happens straight out of STAT (fresh status) or after an RX drain (captured status).
  assign pop = ((state == S_STAT) && !IN_PORT[0] && IN_PORT[1] && !tx_empty) ||
               ((state == S_RDRX) && stat[1] && !tx_empty);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= tx_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Strobes are launched on the edge that enters their state, so READ is live
  // during STAT/RDRX and IN_PORT can be captured in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CFG;
      stat     <= '0;
      cfg_val  <= CFG_INIT;
      cfg_lat  <= '0;
      cfg_pend <= 1'b0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      OUT_PORT <= '0;
      WRITE2   <= 1'b0;
      WRITE0   <= 1'b0;
      READ     <= '0;
      INT_ACK  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovf   <= 1'b0;
`ifdef UART_SEQ_ERR_DROP_EN
      err_drop_cnt <= '0;
`endif
    end else begin
      WRITE2   <= 1'b0;
      WRITE0   <= 1'b0;
      READ     <= 3'b000;
      INT_ACK  <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b1;
      case (state)
        S_CFG: begin
          if (WRITE2) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            WRITE2   <= 1'b1;
            OUT_PORT <= cfg_val;
          end
        end
        S_IDLE: begin
          if (cfg_pend) begin
            state    <= S_CFG;
            cfg_val  <= cfg_lat;
            cfg_pend <= 1'b0;
            WRITE2   <= 1'b1;
            OUT_PORT <= cfg_lat;
          end else if (INTERRUPT) begin
            state   <= S_ACK;
            INT_ACK <= 1'b1;
          end else if (!tx_empty) begin
            state <= S_STAT;
            READ  <= 3'b010;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ACK: begin
          state <= S_STAT;
          READ  <= 3'b010;
        end
        S_STAT: begin
          stat <= IN_PORT[4:0];
          if (IN_PORT[0]) begin
            state <= S_RDRX;
            READ  <= 3'b001;
          end else if (pop) begin
            state    <= S_WRTX;
            WRITE0   <= 1'b1;
            OUT_PORT <= fifo_head;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_RDRX: begin
          rx_data <= IN_PORT;
          rx_perr <= stat[2];
          rx_ferr <= stat[3];
          rx_ovf  <= stat[4];
`ifdef UART_SEQ_ERR_DROP_EN
          if (stat[2] | stat[3]) err_drop_cnt <= sat_inc8(err_drop_cnt);
          else                   rx_valid     <= 1'b1;
`else
          rx_valid <= 1'b1;
`endif
          if (pop) begin
            state    <= S_WRTX;
            WRITE0   <= 1'b1;
            OUT_PORT <= fifo_head;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WRTX: begin
          state    <= S_HOLD;
          hold_cnt <= '0;
        end
        S_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_CFG;
      endcase
      // A new request always wins over the clear on CFG entry in the same cycle.
      if (cfg_wr) begin
        cfg_lat  <= cfg_din;
        cfg_pend <= 1'b1;
      end
    end
  end

endmodule
